// File: rtl/comp_hash_lookup.sv
// rtl/comp_hash_lookup.sv - LZRW1 hash-table lookup stage: hash key, return last position, store current
module comp_hash_lookup #(
    parameter int TABLE_BITS = 12,
    parameter int PTR_BITS   = 12,
    parameter int HASH_MULT  = 40543
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [23:0]           toHash,
    input  logic [PTR_BITS-1:0]   bytePtr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PTR_BITS-1:0]   offset,
    output logic                  hit,
    output logic [TABLE_BITS-1:0] hash,
    output logic                  busy
);

    localparam int          ENTRIES = 1 << TABLE_BITS;
    localparam logic [31:0] MULT    = 32'(HASH_MULT);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                state;
    logic [TABLE_BITS-1:0] sweep_cnt;
    logic                  s1_valid;
    logic [TABLE_BITS-1:0] s1_hash;
    logic [PTR_BITS-1:0]   s1_ptr;

    logic                  tbl_valid [ENTRIES];
    logic [PTR_BITS-1:0]   tbl_pos   [ENTRIES];

    logic                  en;
    logic                  accept;
    logic [15:0]           key_mix;
    logic [31:0]           product;
    logic [TABLE_BITS-1:0] hash_c;
    logic                  rd_valid;
    logic [PTR_BITS-1:0]   rd_pos;

    assign key_mix = {toHash[23:16], 8'h00} ^ {4'h0, toHash[15:8], 4'h0} ^ {8'h00, toHash[7:0]};
    assign product = MULT * {16'h0000, key_mix};
    assign hash_c  = TABLE_BITS'(product >> 4);

    assign en       = !out_valid || out_ready;
    assign in_ready = (state == ST_RUN) && en && !clear;
    assign accept   = in_valid && in_ready;

    // S2 reads the table as registered; the previous item's write landed on the
    // same edge that moved this item into S1, so equal-hash neighbours chain correctly.
    assign rd_valid = tbl_valid[s1_hash];
    assign rd_pos   = tbl_pos[s1_hash];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
            s1_valid  <= 1'b0;
            s1_hash   <= '0;
            s1_ptr    <= '0;
            out_valid <= 1'b0;
            offset    <= '0;
            hit       <= 1'b0;
            hash      <= '0;
            busy      <= 1'b1;
        end else if (clear) begin
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            if (state == ST_CLEAR) begin
                sweep_cnt <= sweep_cnt + 1'b1;
                if (sweep_cnt == {TABLE_BITS{1'b1}}) begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end
            end
            if (en) begin
                s1_valid  <= accept;
                if (accept) begin
                    s1_hash <= hash_c;
                    s1_ptr  <= bytePtr;
                end
                out_valid <= s1_valid;
                if (s1_valid) begin
                    offset <= rd_valid ? rd_pos : '0;
                    hit    <= rd_valid && (rd_pos != s1_ptr);
                    hash   <= s1_hash;
                end
            end
        end
    end

    // Table storage is never reset; the sweep is what invalidates it.
    always_ff @(posedge clock) begin
        if (!clear && state == ST_CLEAR) begin
            tbl_valid[sweep_cnt] <= 1'b0;
        end else if (!clear && en && s1_valid) begin
            tbl_valid[s1_hash] <= 1'b1;
            tbl_pos[s1_hash]   <= s1_ptr;
        end
    end

endmodule
